// File: rtl/adc_arbiter.sv
// Round-robin scheduler that shares one 8-bit ADC between two capture consumers.
// Each conversion has a watchdog. When it expires, the conversion is aborted and a sticky error flag is set.
module adc_arbiter #(
   parameter int TIMEOUT    = 255,
   parameter int GAP_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rdy,
   input  logic [7:0] i_dat,
   output logic       o_req,
   input  logic       i_req0,
   input  logic       i_req1,
   output logic       o_rdy0,
   output logic       o_rdy1,
   output logic [7:0] o_dat_out,
   output logic [1:0] o_gnt,
   output logic       o_timeout_err,
   input  logic       i_clr_err
);

   localparam int              WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam bit              GAP_SKIP = (GAP_CYCLES == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DELIVER,
      S_GAP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   state_t          w_afterConv;
   logic            r_rdyQ;
   logic            r_ptr;
   logic [1:0]      r_gnt;
   logic [WD_W-1:0] r_wdog;
   logic [7:0]      r_gapCnt;
   logic [7:0]      r_datOut;
   logic            r_timeoutErr;
   logic            w_edge;
   logic            w_timeout;
   logic            w_busy;
   logic [1:0]      w_pick;

   assign w_edge      = i_rdy & ~r_rdyQ;
   assign w_timeout   = (r_wdog == WD_LAST);
   assign w_afterConv = GAP_SKIP ? S_IDLE : S_GAP;

   // r_ptr = 1 means channel 1 wins a tie; a sole requester always wins.
   always_comb begin
      w_pick = 2'b00;
      if (i_req0 && i_req1) begin
         w_pick = r_ptr ? 2'b10 : 2'b01;
      end else if (i_req0) begin
         w_pick = 2'b01;
      end else if (i_req1) begin
         w_pick = 2'b10;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_pick != 2'b00) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_edge) begin
               w_next = S_DELIVER;
            end else if (w_timeout) begin
               w_next = w_afterConv;
            end
         end
         S_DELIVER: w_next = w_afterConv;
         S_GAP: begin
            if (r_gapCnt == GAP_LAST) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A timeout that fires in the same cycle as clr_err overrides the clear, because it is assigned later.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rdyQ       <= 1'b0;
         r_ptr        <= 1'b0;
         r_gnt        <= 2'b00;
         r_wdog       <= '0;
         r_gapCnt     <= 8'd0;
         r_datOut     <= 8'h00;
         r_timeoutErr <= 1'b0;
      end else begin
         r_rdyQ <= i_rdy;
         if (i_clr_err) r_timeoutErr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_gapCnt <= 8'd0;
               if (w_pick != 2'b00) begin
                  r_gnt  <= w_pick;
                  r_wdog <= '0;
               end
            end
            S_WAIT: begin
               if (w_edge) begin
                  r_datOut <= i_dat;
                  r_ptr    <= r_gnt[0];
               end else if (w_timeout) begin
                  r_timeoutErr <= 1'b1;
                  r_ptr        <= r_gnt[0];
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_GAP: r_gapCnt <= r_gapCnt + 8'd1;
            default: ;
         endcase
      end
   end

   // A strobe is suppressed when its consumer has dropped its request by the time of delivery.
   assign w_busy        = (r_state == S_WAIT) || (r_state == S_DELIVER);
   assign o_req         = (r_state == S_WAIT);
   assign o_gnt         = w_busy ? r_gnt : 2'b00;
   assign o_rdy0        = (r_state == S_DELIVER) && r_gnt[0] && i_req0;
   assign o_rdy1        = (r_state == S_DELIVER) && r_gnt[1] && i_req1;
   assign o_dat_out     = r_datOut;
   assign o_timeout_err = r_timeoutErr;

endmodule
